full_adder_structural: RTL and testbench

- Gate-level (structural) full adder, generalised to a WIDTH-bit ripple-carry chain with a registered output stage.
- Computes {carry, sum} = a + b + Cin.
- Used as the basic arithmetic cell in datapaths. WIDTH=1 gives the classic single-bit full adder.
- One clock; reset is synchronous and active-high.

---
 rtl/full_adder_structural_if.sv | 14 +
 rtl/full_adder_structural.sv | 52 +++++
 tb/tb_full_adder_structural.sv | 135 +++++++++++++
 3 files changed

// File: rtl/full_adder_structural_if.sv
// Operand/result bundle for the ripple-carry adder.
// The master drives the operands; the adder (slave) returns sum and carry.
interface full_adder_structural_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Cin;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (output a, b, Cin, input  sum, carry);
    modport slave  (input  a, b, Cin, output sum, carry);
endinterface

// File: rtl/full_adder_structural.sv
// WIDTH-bit ripple-carry adder built from xor/and/or gate primitives,
// with an optional registered output stage (synchronous active-high reset).
module full_adder_structural #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    full_adder_structural_if.slave bus
);

    wire  [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;

    assign c[0] = bus.Cin;

    // One gate-level full-adder cell per bit; carry ripples LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        wire p, g, t;
        xor u_p (p, bus.a[i], bus.b[i]);
        xor u_s (sum_d[i], p, c[i]);
        and u_g (g, bus.a[i], bus.b[i]);
        and u_t (t, p, c[i]);
        or  u_c (c[i+1], g, t);
    end

    assign carry_d = c[WIDTH];

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;

        // Reset wins over capture, so a result in flight is dropped.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        assign bus.sum   = sum_q;
        assign bus.carry = carry_q;
    end else begin : g_comb
        assign bus.sum   = sum_d;
        assign bus.carry = carry_d;
    end

endmodule

// File: tb/tb_full_adder_structural.sv
// Directed and random checks of the structural adder in three configurations:
// 1-bit registered, 8-bit registered and 1-bit combinational.
module tb_full_adder_structural;

    logic clk = 1'b0;
    logic rst;
    logic clk_c = 1'b0;
    logic rst_c;

    int n_cmp = 0;
    int n_err = 0;

    full_adder_structural_if #(.WIDTH(1)) if1 ();
    full_adder_structural_if #(.WIDTH(8)) if8 ();
    full_adder_structural_if #(.WIDTH(1)) ifc ();

    full_adder_structural #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (.clk(clk),   .rst(rst),   .bus(if1));
    full_adder_structural #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (.clk(clk),   .rst(rst),   .bus(if8));
    full_adder_structural #(.WIDTH(1), .REG_OUT(1'b0)) u_dutc (.clk(clk_c), .rst(rst_c), .bus(ifc));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv1(input logic [2:0] v);
        if1.a   = v[2];
        if1.b   = v[1];
        if1.Cin = v[0];
    endtask

    // {carry,sum} for {a,b,Cin} = 000..111
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Mid-stream reset sequence: inputs, rst, expected {carry,sum}
    logic [2:0] ms_in  [8] = '{3'b000, 3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 3'b000, 3'b111};
    logic       ms_rst [8] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
    logic [1:0] ms_exp [8] = '{2'b00,  2'b11,  2'b00,  2'b11,  2'b00,  2'b00,  2'b00,  2'b11};

    initial begin
        logic [8:0] ref8;
        rst = 1'b1;
        rst_c = 1'b0;
        drv1(3'b000);
        if8.a = 8'h00; if8.b = 8'h00; if8.Cin = 1'b0;
        ifc.a = 1'b0;  ifc.b = 1'b0;  ifc.Cin = 1'b0;

        cyc();
        cyc();
        chk("reset_w1", {if1.carry, if1.sum}, 9'h000);
        chk("reset_w8", {if8.carry, if8.sum}, 9'h000);

        // Truth table, one vector per cycle
        rst = 1'b0;
        for (int v = 0; v < 8; v++) begin
            drv1(3'(v));
            cyc();
            chk($sformatf("tt_%0d", v), {if1.carry, if1.sum}, {7'd0, tt[v]});
        end

        // Reset held for 2 cycles with inputs 111
        drv1(3'b111);
        rst = 1'b1;
        cyc();
        chk("rst_hold0", {if1.carry, if1.sum}, 9'h000);
        cyc();
        chk("rst_hold1", {if1.carry, if1.sum}, 9'h000);
        rst = 1'b0;
        cyc();
        chk("rst_release", {if1.carry, if1.sum}, 9'h003);

        // Alternating 111/000 with single-cycle reset pulses
        for (int i = 0; i < 8; i++) begin
            drv1(ms_in[i]);
            rst = ms_rst[i];
            cyc();
            chk($sformatf("midstream_%0d", i), {if1.carry, if1.sum}, {7'd0, ms_exp[i]});
        end
        rst = 1'b0;

        // 8-bit boundaries
        if8.a = 8'hFF; if8.b = 8'h00; if8.Cin = 1'b1;
        cyc();
        chk("w8_ripple", {if8.carry, if8.sum}, 9'h100);
        if8.a = 8'hFF; if8.b = 8'hFF; if8.Cin = 1'b1;
        cyc();
        chk("w8_all_ones", {if8.carry, if8.sum}, 9'h1FF);
        if8.a = 8'h00; if8.b = 8'h00; if8.Cin = 1'b0;
        cyc();
        chk("w8_zeros", {if8.carry, if8.sum}, 9'h000);
        if8.a = 8'h80; if8.b = 8'h80; if8.Cin = 1'b0;
        cyc();
        chk("w8_msb_carry", {if8.carry, if8.sum}, 9'h100);
        if8.a = 8'h5A; if8.b = 8'h3C; if8.Cin = 1'b1;
        cyc();
        chk("w8_mixed", {if8.carry, if8.sum}, 9'h097);

        // Back-to-back random vectors, each checked one cycle later
        for (int i = 0; i < 1000; i++) begin
            if8.a   = 8'($urandom_range(0, 255));
            if8.b   = 8'($urandom_range(0, 255));
            if8.Cin = 1'($urandom_range(0, 1));
            ref8 = {1'b0, if8.a} + {1'b0, if8.b} + {8'd0, if8.Cin};
            cyc();
            chk($sformatf("w8_rand_%0d", i), {if8.carry, if8.sum}, ref8);
        end

        // Combinational variant, clock held low, reset toggled mid-interval
        for (int v = 0; v < 8; v++) begin
            ifc.a   = 1'(v >> 2);
            ifc.b   = 1'(v >> 1);
            ifc.Cin = 1'(v);
            #50;
            chk($sformatf("comb_%0d", v), {ifc.carry, ifc.sum}, {7'd0, tt[v]});
            rst_c = ~rst_c;
            #1;
            chk($sformatf("comb_rst_%0d", v), {ifc.carry, ifc.sum}, {7'd0, tt[v]});
            #49;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
